// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC expansion-bus initiator: command codes,
// half-T-state encoding and the well-known gate-array/RAM control ports.
// Optional macro Z80_REFRESH_CYCLE_EN adds the refresh half-states.
package cpc_bus_pkg;

  localparam logic [1:0] CMD_MRD  = 2'd0;
  localparam logic [1:0] CMD_MWR  = 2'd1;
  localparam logic [1:0] CMD_IORD = 2'd2;
  localparam logic [1:0] CMD_IOWR = 2'd3;

  localparam logic [15:0] RAM_CTRL_PORT = 16'h7FFF;
  localparam logic [15:0] ROM_CTRL_PORT = 16'h7F00;

  // One state per half T-state; xH states have zclk high, xL states low.
  typedef enum logic [3:0] {
    IDLE, T1H, T1L, T2H, T2L, TWH, TWL, T3H, T3L
`ifdef Z80_REFRESH_CYCLE_EN
    , R1H, R1L, R2H, R2L
`endif
  } half_state_t;

  // Reads are MRD and IORD; bit 0 marks writes, bit 1 marks I/O space.
  function automatic logic is_read_cmd(input logic [1:0] t);
    return (t == CMD_MRD) || (t == CMD_IORD);
  endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// 7-bit Z80 R-register model used to address DRAM refresh cycles.
// Exists only when Z80_REFRESH_CYCLE_EN is defined.
`ifdef Z80_REFRESH_CYCLE_EN
module z80_refresh_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [6:0] r_q
);

  logic [6:0] r_reg;

  // Advance once per completed refresh; 7-bit arithmetic wraps 127 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg <= '0;
    end else if (en) begin
      r_reg <= r_reg + 7'd1;
    end
  end

  assign r_q = r_reg;

endmodule
`endif

// File: rtl/z80_bus_initiator.sv
// Z80-style bus master for the CPC expansion bus: one command at a time,
// generates MREQ/IORQ/RD/WR timing at half-T-state resolution and returns
// read data / WAIT-timeout status on a one-clock response pulse.
// Optional macro Z80_REFRESH_CYCLE_EN appends a refresh cycle after every MRD.
module z80_bus_initiator
  import cpc_bus_pkg::*;
#(
  parameter int MAX_WAIT     = 255,  // must be >= 1
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        zclk,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        rfsh_b,
  input  logic        wait_b
);

  localparam int            CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_WAIT);
  localparam bit            AUTO_WAIT = (IO_AUTO_WAIT != 0);

  half_state_t   state_reg, state_next;
  logic          zclk_reg;
  logic [1:0]    type_reg, type_next;
  logic [15:0]   adr_reg, adr_next;
  logic [7:0]    dout_reg, dout_next;
  logic [7:0]    rdata_reg, rdata_next;
  logic [CW-1:0] cnt_reg, cnt_next;     // non-forced TW pairs taken so far
  logic          wait_reg, wait_next;   // last sampled wait request
  logic          err_reg, err_next;
  logic          rsp_valid_reg, rsp_err_reg;
  logic          mreq_reg, iorq_reg, rd_reg, wr_reg, oe_reg;
  logic          mreq_next, iorq_next, rd_next, wr_next, oe_next;
  logic          ph_t1l_t3h, ph_t2h_t3h, ph_t2l_t3h, ph_t1l_t3l;
  logic          nt_mem, nt_rd, nt_wr;
  logic          accept;

`ifdef Z80_REFRESH_CYCLE_EN
  logic       rfsh_reg, rfsh_next;
  logic [6:0] r_q;

  z80_refresh_ctr u_refresh_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (state_reg == R2L),
    .r_q   (r_q)
  );
`endif

  assign cmd_ready = (state_reg == IDLE) && !zclk_reg;
  assign accept    = cmd_valid && cmd_ready;

  // Half-state sequencing, command latch, WAIT sampling and timeout.
  always_comb begin
    state_next = state_reg;
    type_next  = type_reg;
    adr_next   = adr_reg;
    dout_next  = dout_reg;
    rdata_next = rdata_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = T1H;
          type_next  = cmd_type;
          adr_next   = cmd_addr;
          dout_next  = cmd_data;
          cnt_next   = '0;
          wait_next  = 1'b0;
          err_next   = 1'b0;
        end
      end
      T1H: state_next = T1L;
      T1L: state_next = T2H;
      T2H: begin
        wait_next  = !wait_b;
        state_next = T2L;
      end
      T2L: begin
        // I/O always takes the forced pair; its TWH does the real sample.
        if (type_reg[1] && AUTO_WAIT) begin
          state_next = TWH;
        end else if (wait_reg) begin
          state_next = TWH;
          cnt_next   = CW'(1);
        end else begin
          state_next = T3H;
        end
      end
      TWH: begin
        wait_next  = !wait_b;
        state_next = TWL;
      end
      TWL: begin
        if (!wait_reg) begin
          state_next = T3H;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = T3H;
          err_next   = 1'b1;
        end else begin
          state_next = TWH;
          cnt_next   = cnt_reg + CW'(1);
        end
      end
      T3H: begin
        if (is_read_cmd(type_reg)) rdata_next = data_in;
        state_next = T3L;
      end
      T3L: begin
        state_next = IDLE;
`ifdef Z80_REFRESH_CYCLE_EN
        if (type_reg == CMD_MRD) begin
          state_next = R1H;
          adr_next   = {9'b0, r_q};
        end
`endif
      end
`ifdef Z80_REFRESH_CYCLE_EN
      R1H: state_next = R1L;
      R1L: state_next = R2H;
      R2H: state_next = R2L;
      R2L: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Strobe decode for the upcoming half-state so outputs come from flops.
  always_comb begin
    ph_t1l_t3h = 1'b0;
    ph_t2h_t3h = 1'b0;
    ph_t2l_t3h = 1'b0;
    ph_t1l_t3l = 1'b0;
    case (state_next)
      T1L: begin
        ph_t1l_t3h = 1'b1;
        ph_t1l_t3l = 1'b1;
      end
      T2H: begin
        ph_t1l_t3h = 1'b1;
        ph_t2h_t3h = 1'b1;
        ph_t1l_t3l = 1'b1;
      end
      T2L, TWH, TWL, T3H: begin
        ph_t1l_t3h = 1'b1;
        ph_t2h_t3h = 1'b1;
        ph_t2l_t3h = 1'b1;
        ph_t1l_t3l = 1'b1;
      end
      T3L: ph_t1l_t3l = 1'b1;
      default: ;
    endcase
    nt_mem    = !type_next[1];
    nt_rd     = is_read_cmd(type_next);
    nt_wr     = type_next[0];
    mreq_next = !(nt_mem && ph_t1l_t3h);
    iorq_next = !(!nt_mem && ph_t2h_t3h);
    rd_next   = !(nt_rd && (nt_mem ? ph_t1l_t3h : ph_t2h_t3h));
    wr_next   = !(nt_wr && (nt_mem ? ph_t2l_t3h : ph_t2h_t3h));
    oe_next   = nt_wr && ph_t1l_t3l;
`ifdef Z80_REFRESH_CYCLE_EN
    rfsh_next = !(state_next inside {R1H, R1L, R2H, R2L});
    if (state_next inside {R1L, R2H}) mreq_next = 1'b0;
`endif
  end

  // State, datapath and registered bus outputs; reset releases strobes at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      zclk_reg      <= 1'b0;
      type_reg      <= CMD_MRD;
      adr_reg       <= '0;
      dout_reg      <= '0;
      rdata_reg     <= '0;
      cnt_reg       <= '0;
      wait_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      mreq_reg      <= 1'b1;
      iorq_reg      <= 1'b1;
      rd_reg        <= 1'b1;
      wr_reg        <= 1'b1;
      oe_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      zclk_reg      <= !zclk_reg;
      type_reg      <= type_next;
      adr_reg       <= adr_next;
      dout_reg      <= dout_next;
      rdata_reg     <= rdata_next;
      cnt_reg       <= cnt_next;
      wait_reg      <= wait_next;
      err_reg       <= err_next;
      rsp_valid_reg <= (state_reg == T3L);
      rsp_err_reg   <= (state_reg == T3L) && err_reg;
      mreq_reg      <= mreq_next;
      iorq_reg      <= iorq_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
      oe_reg        <= oe_next;
    end
  end

`ifdef Z80_REFRESH_CYCLE_EN
  // Refresh strobe register.
  always_ff @(posedge clk) begin
    if (reset) rfsh_reg <= 1'b1;
    else       rfsh_reg <= rfsh_next;
  end
  assign rfsh_b = rfsh_reg;
`else
  assign rfsh_b = 1'b1;
`endif

  assign zclk      = zclk_reg;
  assign adr       = adr_reg;
  assign data_out  = dout_reg;
  assign data_oe   = oe_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rdata_reg;
  assign mreq_b    = mreq_reg;
  assign iorq_b    = iorq_reg;
  assign rd_b      = rd_reg;
  assign wr_b      = wr_reg;

endmodule

// File: tb/tb_z80_bus_initiator.sv
// Bench for z80_bus_initiator: reset/idle checks, a directed vector table,
// randomized commands against a T-state arithmetic model, reset mid-cycle,
// and (with Z80_REFRESH_CYCLE_EN) a refresh-address wrap run.
module tb_z80_bus_initiator;
  import cpc_bus_pkg::*;

  localparam int MAX_WAIT     = 4;
  localparam int IO_AUTO_WAIT = 1;
`ifdef Z80_REFRESH_CYCLE_EN
  localparam int REFRESH = 1;
`else
  localparam int REFRESH = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_addr, adr;
  logic [7:0]  cmd_data, rsp_data, data_out, data_in;
  logic        rsp_valid, rsp_err, zclk, data_oe;
  logic        mreq_b, iorq_b, rd_b, wr_b, rfsh_b, wait_b;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  last_rd = 8'h00;
  int          r_model = 0;
  int          txn_no = 0;

  typedef struct {
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
    int          w;        // consecutive wait_b=0 samples
    logic [7:0]  rdval;
    int          lat;      // accept edge counted as clk 1
    int          err;
    int          mreq_lo, iorq_lo, rd_lo, wr_lo, oe_hi;
  } vec_t;

  vec_t vecs[7];

  z80_bus_initiator #(.MAX_WAIT(MAX_WAIT), .IO_AUTO_WAIT(IO_AUTO_WAIT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .zclk(zclk), .adr(adr), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b),
    .wr_b(wr_b), .rfsh_b(rfsh_b), .wait_b(wait_b)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected behaviour from T-state counting: each TW pair adds 2 clks.
  function automatic vec_t model(input logic [1:0] typ, input logic [15:0] addr,
                                 input logic [7:0] data, input int w, input logic [7:0] rdval);
    vec_t v;
    int p, n;
    p = (w < MAX_WAIT) ? w : MAX_WAIT;
    n = p + (typ[1] ? IO_AUTO_WAIT : 0);
    v.typ = typ; v.addr = addr; v.data = data; v.w = w; v.rdval = rdval;
    v.lat = 7 + 2 * n;
    v.err = (w > MAX_WAIT) ? 1 : 0;
    v.mreq_lo = typ[1] ? 0 : 4 + 2 * n;
    v.iorq_lo = typ[1] ? 3 + 2 * n : 0;
    v.rd_lo = 0; v.wr_lo = 0; v.oe_hi = 0;
    case (typ)
      CMD_MRD:  v.rd_lo = 4 + 2 * n;
      CMD_MWR:  begin v.wr_lo = 2 + 2 * n; v.oe_hi = 5 + 2 * n; end
      CMD_IORD: v.rd_lo = 3 + 2 * n;
      default:  begin v.wr_lo = 3 + 2 * n; v.oe_hi = 5 + 2 * n; end
    endcase
    return v;
  endfunction

  // Issue one command (called at a negedge) and check its whole bus cycle.
  task automatic run_txn(input vec_t v);
    int n_mreq = 0, n_iorq = 0, n_rd = 0, n_wr = 0, n_oe = 0, n_rfsh = 0;
    int n_rsp = 0, rsp_k = -1, bad_adr = 0, bad_dout = 0, bad_zclk = 0;
    int lowlim, guard;
    logic [7:0] got_d = 8'h00;
    logic got_e = 1'b0;
    logic [15:0] rf_adr = 16'hFFFF;
    logic [7:0] exp_d;
    lowlim = (v.w == 0) ? 0 : 1 + 2 * (v.typ[1] ? IO_AUTO_WAIT : 0) + 2 * v.w;
    cmd_valid = 1'b1; cmd_type = v.typ; cmd_addr = v.addr; cmd_data = v.data;
    wait_b = 1'b1; data_in = ~v.rdval;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom); cmd_addr = 16'($urandom); cmd_data = 8'($urandom);
    for (int k = 0; k <= v.lat + 3; k++) begin
      if (mreq_b === 1'b0) n_mreq++;
      if (iorq_b === 1'b0) n_iorq++;
      if (rd_b === 1'b0) n_rd++;
      if (wr_b === 1'b0) n_wr++;
      if (data_oe === 1'b1) n_oe++;
      if (rfsh_b === 1'b0) n_rfsh++;
      if (zclk !== ((k % 2) == 0)) bad_zclk++;
      if (k <= v.lat - 2 && adr !== v.addr) bad_adr++;
      if (wr_b === 1'b0 && data_out !== v.data) bad_dout++;
      if (rsp_valid === 1'b1) begin
        n_rsp++; rsp_k = k; got_d = rsp_data; got_e = rsp_err;
      end
      if (k == v.lat - 1) rf_adr = adr;
      wait_b  = (k + 1 <= lowlim) ? 1'b0 : 1'b1;
      data_in = (k + 1 == v.lat - 2) ? v.rdval : ~v.rdval;
      @(negedge clk);
    end
    wait_b = 1'b1;
    exp_d = is_read_cmd(v.typ) ? v.rdval : last_rd;
    chk("rsp_latency", 32'(rsp_k + 1), 32'(v.lat));
    chk("rsp_pulses", 32'(n_rsp), 32'd1);
    chk("rsp_err", 32'(got_e), 32'(v.err));
    chk("rsp_data", 32'(got_d), 32'(exp_d));
    chk("mreq_low_clks", 32'(n_mreq), 32'(v.mreq_lo + ((REFRESH != 0 && v.typ == CMD_MRD) ? 2 : 0)));
    chk("iorq_low_clks", 32'(n_iorq), 32'(v.iorq_lo));
    chk("rd_low_clks", 32'(n_rd), 32'(v.rd_lo));
    chk("wr_low_clks", 32'(n_wr), 32'(v.wr_lo));
    chk("data_oe_clks", 32'(n_oe), 32'(v.oe_hi));
    chk("rfsh_low_clks", 32'(n_rfsh), 32'((REFRESH != 0 && v.typ == CMD_MRD) ? 4 : 0));
    chk("adr_hold_errors", 32'(bad_adr), 32'd0);
    chk("data_out_errors", 32'(bad_dout), 32'd0);
    chk("zclk_phase_errors", 32'(bad_zclk), 32'd0);
`ifdef Z80_REFRESH_CYCLE_EN
    if (v.typ == CMD_MRD) begin
      chk("rfsh_adr", 32'(rf_adr), 32'(r_model));
      r_model = (r_model + 1) % 128;
    end
`endif
    if (is_read_cmd(v.typ)) last_rd = v.rdval;
    $display("txn %0d type=%0d addr=%04h w=%0d lat=%0d rsp_data=%02h rsp_err=%0b",
             txn_no, v.typ, v.addr, v.w, rsp_k + 1, got_d, got_e);
    txn_no++;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_type = CMD_MRD; cmd_addr = 16'h0;
    cmd_data = 8'h0; data_in = 8'h0; wait_b = 1'b1;

    // Directed vectors; expected values counted by hand from the cycle shapes.
    vecs[0] = '{CMD_MWR,  16'h4000,      8'hA5, 0,  8'h00, 7,  0, 4,  0, 0,  2, 5};
    vecs[1] = '{CMD_IOWR, RAM_CTRL_PORT, 8'hC4, 0,  8'h00, 9,  0, 0,  5, 0,  5, 7};
    vecs[2] = '{CMD_MRD,  16'hC000,      8'h00, 3,  8'h3C, 13, 0, 10, 0, 10, 0, 0};
    vecs[3] = '{CMD_MRD,  16'h1234,      8'h00, 99, 8'h5A, 15, 1, 12, 0, 12, 0, 0};
    vecs[4] = '{CMD_MRD,  16'h8000,      8'h00, 4,  8'hE7, 15, 0, 12, 0, 12, 0, 0};
    vecs[5] = '{CMD_IORD, ROM_CTRL_PORT, 8'h00, 2,  8'h77, 13, 0, 0,  9, 9,  0, 0};
    vecs[6] = '{CMD_MWR,  16'hFFFF,      8'h5A, 1,  8'h00, 9,  0, 6,  0, 0,  4, 7};

    repeat (3) @(negedge clk);
    chk("reset_mreq_b", 32'(mreq_b), 32'd1);
    chk("reset_iorq_b", 32'(iorq_b), 32'd1);
    chk("reset_rd_b", 32'(rd_b), 32'd1);
    chk("reset_wr_b", 32'(wr_b), 32'd1);
    chk("reset_rfsh_b", 32'(rfsh_b), 32'd1);
    chk("reset_data_oe", 32'(data_oe), 32'd0);
    chk("reset_adr", 32'(adr), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_zclk", 32'(zclk), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_zclk", 32'(zclk), 32'((i % 2) == 0));
      chk("idle_cmd_ready", 32'(cmd_ready), 32'((i % 2) != 0));
      chk("idle_strobes", 32'({mreq_b, iorq_b, rd_b, wr_b, rfsh_b, data_oe}), 32'b111110);
    end

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset asserted while an IORD sits in its forced TWL.
    begin
      int guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      chk("mid_reset_ready_seen", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_type = CMD_IORD; cmd_addr = ROM_CTRL_PORT; wait_b = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_iorq_b", 32'(iorq_b), 32'd0);
      chk("pre_reset_rd_b", 32'(rd_b), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_reset_strobes", 32'({mreq_b, iorq_b, rd_b, wr_b, rfsh_b}), 32'b11111);
      chk("mid_reset_data_oe", 32'(data_oe), 32'd0);
      chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_reset_rsp_data", 32'(rsp_data), 32'd0);
      chk("mid_reset_zclk", 32'(zclk), 32'd0);
      reset = 1'b0;
      last_rd = 8'h00;
      r_model = 0;
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] t;
      int w;
      t = 2'($urandom_range(0, 3));
      w = t[1] ? $urandom_range(0, 2) : $urandom_range(0, 6);
      run_txn(model(t, 16'($urandom), 8'($urandom), w, 8'($urandom)));
    end

`ifdef Z80_REFRESH_CYCLE_EN
    for (int i = 0; i < 130; i++) begin
      run_txn(model(CMD_MRD, 16'($urandom), 8'h00, 0, 8'($urandom)));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_bus_initiator.md
Name: z80_bus_initiator

Overview:
- Synthesisable Z80-style bus master that generates CPC expansion-bus cycles: memory read/write, I/O read/write, and optional refresh.
- Drives the same MREQ/IORQ/RD/WR/WAIT protocol that the RAM expansion CPLDs respond to.
- Used in the board-level test harness and in the standalone memory-tester CPLD to exercise 0x7FXX bank selects and banked RAM.
- Accepts one command at a time over a valid/ready interface and returns read data and status on a one-cycle response pulse.

Parameters:
- MAX_WAIT, 255: WAIT T-states tolerated before timeout; wait counter width is $clog2(MAX_WAIT+1).
- IO_AUTO_WAIT, 1: automatic Tw states inserted in every I/O cycle (0 or 1).

Ports:
- clk  in  1  system clock, 2x Z80 clock; one clk = one half T-state.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising clk.
- cmd_type  in  2  0=MRD, 1=MWR, 2=IORD, 3=IOWR.
- cmd_addr  in  16  bus address.
- cmd_data  in  8  write data.
- rsp_valid  out  1  one-clk completion pulse.
- rsp_data  out  8  read data; holds last value.
- rsp_err  out  1  WAIT timeout flag; valid with rsp_valid.
- zclk  out  1  generated Z80 clock.
- adr  out  16  address bus.
- data_out  out  8  write data.
- data_oe  out  1  data-bus drive enable.
- data_in  in  8  bus data.
- mreq_b, iorq_b, rd_b, wr_b, rfsh_b  out  1 each  active-low strobes.
- wait_b  in  1  active-low wait request.

Behaviour:
- Reset values: mreq_b=iorq_b=rd_b=wr_b=rfsh_b=1, data_oe=0, adr=0, data_out=0, rsp_valid=0, rsp_err=0, rsp_data=0, zclk=0, state=IDLE. Strobes return high on the first edge after reset is sampled, even mid-cycle.
- zclk toggles every clk, always. It is high in xH states and low in xL states.
- cmd_ready=1 only when state=IDLE and zclk=0. Acceptance latches type, addr and data; the next state is T1H.
- Half-state sequence: T1H, T1L, T2H, T2L, [TWH, TWL]*, T3H, T3L, then IDLE.
- Memory read:
  - adr is driven from T1H.
  - mreq_b and rd_b are low T1L through T3H.
  - data_in is captured into rsp_data on the clk edge that ends T3H.
- Memory write:
  - data_oe=1 and mreq_b=0 from T1L.
  - wr_b=0 during T2L and T3H.
  - mreq_b and wr_b are high in T3L. data_oe drops on IDLE entry.
- I/O read/write:
  - data_oe from T1L for IOWR only.
  - iorq_b and rd_b/wr_b are low T2H through T3H.
  - IO_AUTO_WAIT forced TW pairs are inserted after T2L regardless of wait_b.
- WAIT handling:
  - wait_b is sampled on the edge ending T2H (memory) or the final forced TWH (I/O).
  - If wait_b=0, the cycle goes T2L→TWH→TWL and wait_b is resampled at the end of each TWH.
  - A wait counter increments per TW pair. When it reaches MAX_WAIT, the cycle proceeds to T3 regardless and rsp_err=1 in the response.
- rsp_valid pulses in the clk after T3L, which is also the first IDLE clk.
- Latency from accept edge to rsp_valid:
  - Memory: 7 clks.
  - I/O: 7+2*IO_AUTO_WAIT clks.
  - Each extra wait T-state adds 2 clks.
- cmd_type is decoded once at acceptance. Changes to cmd_* after acceptance are ignored.
- adr holds its last value in IDLE.

Optional Feature:
- Macro Z80_REFRESH_CYCLE_EN.
- Defined:
  - After every MRD, T3L is followed by R1H, R1L, R2H, R2L before IDLE.
  - rfsh_b=0 throughout R1H–R2L; adr={9'b0, r_q[6:0]}; mreq_b=0 in R1L and R2H.
  - r_q increments after R2L and wraps 127→0; reset value 0.
  - rsp_valid still pulses in the clk after T3L.
  - cmd_ready stays low until IDLE is reached after R2L.
- Not defined: rfsh_b is constant 1, no R states exist, and r_q is absent.

Decomposition:
- Package cpc_bus_pkg holds:
  - cmd type constants CMD_MRD, CMD_MWR, CMD_IORD, CMD_IOWR;
  - the half-state enum;
  - constants RAM_CTRL_PORT=16'h7FFF and ROM_CTRL_PORT=16'h7F00.
- Sub-module z80_refresh_ctr: 7-bit wrapping refresh counter with enable. It is instantiated only under Z80_REFRESH_CYCLE_EN.

Test Plan:
- Reset, then idle for 10 clks → all strobes 1, data_oe=0, zclk toggling, cmd_ready high every other clk.
- MWR addr=0x4000 data=0xA5, wait_b=1 → mreq_b low 4 clks, wr_b low 2 clks with data_out=0xA5, rsp_valid 7 clks after accept, rsp_err=0.
- IOWR addr=0x7FFF data=0xC4, IO_AUTO_WAIT=1 → iorq_b low 5 clks, wr_b low 5 clks, mreq_b stays 1, rsp_valid at clk 9.
- MRD addr=0xC000, wait_b low for 3 samples, data_in=0x3C at T3H → rsp_valid at clk 13, rsp_data=0x3C.
- MAX_WAIT=4, wait_b stuck 0 on MRD → 4 TW pairs, strobes released in T3L, rsp_err=1.
- reset pulsed during TWL of an IORD → next clk all strobes 1 and data_oe=0. With Z80_REFRESH_CYCLE_EN, 130 MRDs → adr[6:0] wraps 127→0 and rfsh_b low 4 clks per read.
